// File: rtl/gp_reg_wr_arbiter.sv
// Round-robin write arbiter and setup/strobe/hold sequencer for a bank of
// general-purpose registers sharing one write path between NUM_REQ agents.
module gp_reg_wr_arbiter #(
    parameter int bus_width = 15,
    parameter int NUM_REQ   = 4,
    parameter int NUM_REGS  = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                             sysclk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ADDR_W-1:0]        req_addr,
    input  logic [NUM_REQ*(bus_width+1)-1:0] req_data,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic [NUM_REQ-1:0]               err,
    output logic                             busy,
    output logic                             wrb,
    output logic [NUM_REGS-1:0]              reg_sel,
    output logic [bus_width:0]               wdata
);

    localparam int DW    = bus_width + 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [PTR_W-1:0]    ptr_r;
    logic [PTR_W-1:0]    ptr_s;
    logic [PTR_W-1:0]    win_r;
    logic [PTR_W-1:0]    win_n_s;
    logic                legal_r;
    logic                legal_n_s;

    logic [PTR_W-1:0]    win_s;
    logic [PTR_W-1:0]    cand_s;
    logic                any_req_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DW-1:0]       data_s;
    logic                legal_s;

    logic [NUM_REQ-1:0]  gnt_r,  gnt_s;
    logic [NUM_REQ-1:0]  done_r, done_s;
    logic [NUM_REQ-1:0]  err_r,  err_s;
    logic                busy_r, busy_s;
    logic                wrb_r,  wrb_s;
    logic [NUM_REGS-1:0] reg_sel_r, reg_sel_s;
    logic [DW-1:0]       wdata_r, wdata_s;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (int'(a) == i);
        end
        return v;
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [PTR_W-1:0] w);
        logic [NUM_REQ-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (int'(w) == i);
        end
        return v;
    endfunction

    // Round-robin search starting just after the last winner, with wrap.
    always_comb begin
        win_s     = ptr_r;
        cand_s    = ptr_r;
        any_req_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!any_req_s && req[cand_s]) begin
                any_req_s = 1'b1;
                win_s     = cand_s;
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    // Select the winner's packed address and data.
    always_comb begin
        addr_s = '0;
        data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == PTR_W'(i)) begin
                addr_s = req_addr[i*ADDR_W +: ADDR_W];
                data_s = req_data[i*DW +: DW];
            end else begin
                addr_s = addr_s;
            end
        end
        legal_s = (int'(addr_s) < NUM_REGS);
    end

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = IDLE;
        case (state_r)
            IDLE:    state_s = any_req_s ? SETUP : IDLE;
            SETUP:   state_s = STROBE;
            STROBE:  state_s = HOLD;
            HOLD:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being left.
    always_comb begin
        gnt_s     = '0;
        done_s    = '0;
        err_s     = '0;
        wrb_s     = 1'b1;
        reg_sel_s = reg_sel_r;
        wdata_s   = wdata_r;
        busy_s    = (state_s != IDLE);
        ptr_s     = ptr_r;
        win_n_s   = win_r;
        legal_n_s = legal_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    gnt_s     = req_onehot(win_s);
                    wdata_s   = data_s;
                    reg_sel_s = legal_s ? addr_onehot(addr_s) : '0;
                    ptr_s     = win_s;
                    win_n_s   = win_s;
                    legal_n_s = legal_s;
                end else begin
                    reg_sel_s = '0;
                end
            end
            SETUP: begin
                wrb_s = ~legal_r;
            end
            STROBE: begin
                if (legal_r) begin
                    done_s = req_onehot(win_r);
                end else begin
                    err_s  = req_onehot(win_r);
                end
            end
            HOLD: begin
                reg_sel_s = '0;
            end
            default: begin
                reg_sel_s = '0;
            end
        endcase
    end

    // Output, pointer and transaction-capture registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            ptr_r     <= PTR_W'(NUM_REQ - 1);
            win_r     <= '0;
            legal_r   <= 1'b0;
            gnt_r     <= '0;
            done_r    <= '0;
            err_r     <= '0;
            busy_r    <= 1'b0;
            wrb_r     <= 1'b1;
            reg_sel_r <= '0;
            wdata_r   <= '0;
        end else begin
            ptr_r     <= ptr_s;
            win_r     <= win_n_s;
            legal_r   <= legal_n_s;
            gnt_r     <= gnt_s;
            done_r    <= done_s;
            err_r     <= err_s;
            busy_r    <= busy_s;
            wrb_r     <= wrb_s;
            reg_sel_r <= reg_sel_s;
            wdata_r   <= wdata_s;
        end
    end

    assign gnt     = gnt_r;
    assign done    = done_r;
    assign err     = err_r;
    assign busy    = busy_r;
    assign wrb     = wrb_r;
    assign reg_sel = reg_sel_r;
    assign wdata   = wdata_r;

endmodule

// File: tb/tb_gp_reg_wr_arbiter.sv
// Directed bench for gp_reg_wr_arbiter: a 4-register instance and a 3-register
// instance share stimulus so illegal-address handling can be observed.
module tb_gp_reg_wr_arbiter;

    logic        sysclk;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [63:0] req_data;

    logic [3:0]  gnt_a, done_a, err_a, reg_sel_a;
    logic        busy_a, wrb_a;
    logic [15:0] wdata_a;
    logic [3:0]  gnt_b, done_b, err_b;
    logic [2:0]  reg_sel_b;
    logic        busy_b, wrb_b;
    logic [15:0] wdata_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    gp_reg_wr_arbiter u_dut_a (
        .sysclk(sysclk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt_a), .done(done_a), .err(err_a),
        .busy(busy_a), .wrb(wrb_a), .reg_sel(reg_sel_a), .wdata(wdata_a)
    );

    gp_reg_wr_arbiter #(.NUM_REGS(3)) u_dut_b (
        .sysclk(sysclk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt_b), .done(done_b), .err(err_b),
        .busy(busy_b), .wrb(wrb_b), .reg_sel(reg_sel_b), .wdata(wdata_b)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int idx, input logic [1:0] a, input logic [15:0] d);
        req_addr[idx*2 +: 2]   = a;
        req_data[idx*16 +: 16] = d;
    endtask

    logic [3:0] ga1, ga2, gb1, gb2;
    logic [3:0] w1h;

    initial begin
        reset = 1'b1; req = 4'b0000; req_addr = 8'h00; req_data = 64'h0;
        tick(); tick();
        chk("rst_gnt", gnt_a, 32'h0);
        chk("rst_done", done_a, 32'h0);
        chk("rst_err", err_a, 32'h0);
        chk("rst_busy", busy_a, 32'h0);
        chk("rst_wrb", wrb_a, 32'h1);
        chk("rst_sel", reg_sel_a, 32'h0);
        chk("rst_wdata", wdata_a, 32'h0);
        reset = 1'b0;

        // single legal write
        req = 4'b0001; set_req(0, 2'd2, 16'hA5A5);
        tick();
        chk("t1_gnt", gnt_a, 32'h1);
        chk("t1_busy", busy_a, 32'h1);
        chk("t1_wrb_setup", wrb_a, 32'h1);
        chk("t1_sel_setup", reg_sel_a, 32'h4);
        chk("t1_wdata_setup", wdata_a, 32'hA5A5);
        req = 4'b0000;
        tick();
        chk("t1_wrb_strobe", wrb_a, 32'h0);
        chk("t1_sel_strobe", reg_sel_a, 32'h4);
        chk("t1_wdata_strobe", wdata_a, 32'hA5A5);
        chk("t1_gnt_clear", gnt_a, 32'h0);
        tick();
        chk("t1_done", done_a, 32'h1);
        chk("t1_wrb_hold", wrb_a, 32'h1);
        chk("t1_err", err_a, 32'h0);
        tick();
        chk("t1_sel_idle", reg_sel_a, 32'h0);
        chk("t1_busy_idle", busy_a, 32'h0);
        chk("t1_done_clear", done_a, 32'h0);
        chk("t1_wdata_keep", wdata_a, 32'hA5A5);

        // all requesting: 0,1,2,3,0 every 4 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 16'(16'h1000 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w1h = 4'b0001 << (k % 4);
            tick();
            chk("t2_gnt", gnt_a, 32'(w1h));
            chk("t2_wdata", wdata_a, 32'(16'h1000 + (k % 4)));
            chk("t2_sel", reg_sel_a, 32'(w1h));
            chk("t2_gnt_b", gnt_b, 32'(w1h));
            tick();
            chk("t2_wrb", wrb_a, 32'h0);
            chk("t2_wrb_b", wrb_b, (k % 4 == 3) ? 32'h1 : 32'h0);
            tick();
            chk("t2_done", done_a, 32'(w1h));
            chk("t2_err_b", err_b, (k % 4 == 3) ? 32'(w1h) : 32'h0);
            tick();
            chk("t2_busy_idle", busy_a, 32'h0);
        end

        // wrap past 3 after winner 2
        req = 4'b0100;
        tick();
        chk("t3_gnt2", gnt_a, 32'h4);
        req = 4'b0101;
        tick(); tick(); tick(); tick();
        chk("t3_gnt0", gnt_a, 32'h1);
        req = 4'b0100;
        tick(); tick(); tick(); tick();
        chk("t3_gnt2b", gnt_a, 32'h4);
        req = 4'b0000;
        tick(); tick(); tick();

        // illegal address on 3-register instance
        req = 4'b0010; set_req(1, 2'd3, 16'hBEEF);
        tick();
        chk("t4_gnt_b", gnt_b, 32'h2);
        chk("t4_sel_b_setup", reg_sel_b, 32'h0);
        chk("t4_wrb_b_setup", wrb_b, 32'h1);
        req = 4'b0000;
        tick();
        chk("t4_wrb_b_strobe", wrb_b, 32'h1);
        chk("t4_sel_b_strobe", reg_sel_b, 32'h0);
        chk("t4_wrb_a_strobe", wrb_a, 32'h0);
        chk("t4_sel_a_strobe", reg_sel_a, 32'h8);
        tick();
        chk("t4_err_b", err_b, 32'h2);
        chk("t4_done_b", done_b, 32'h0);
        chk("t4_done_a", done_a, 32'h2);
        chk("t4_err_a", err_a, 32'h0);
        tick();

        // reset during STROBE
        req = 4'b0100; set_req(2, 2'd1, 16'h1234);
        tick();
        chk("t5_gnt", gnt_a, 32'h4);
        req = 4'b0000;
        tick();
        chk("t5_wrb_strobe", wrb_a, 32'h0);
        chk("t5_sel_strobe", reg_sel_a, 32'h2);
        reset = 1'b1;
        tick();
        chk("t5_wrb", wrb_a, 32'h1);
        chk("t5_sel", reg_sel_a, 32'h0);
        chk("t5_busy", busy_a, 32'h0);
        chk("t5_done", done_a, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 16'(16'h2000 + i));
        req = 4'b1111;
        tick();
        chk("t5_ptr_gnt", gnt_a, 32'h1);
        chk("t5_no_done", done_a, 32'h0);
        req = 4'b0000;
        tick(); tick(); tick();

        // random traffic: invariants and grant -> done/err two cycles later
        ga1 = 4'h0; ga2 = 4'h0; gb1 = 4'h0; gb2 = 4'h0;
        for (int n = 0; n < 2000; n++) begin
            req      = 4'($urandom_range(0, 15));
            req_addr = 8'($urandom);
            req_data = {$urandom, $urandom};
            tick();
            chk("r_sel_a", 32'($onehot0(reg_sel_a)), 32'h1);
            chk("r_sel_b", 32'($onehot0(reg_sel_b)), 32'h1);
            chk("r_wrb_a", 32'(!wrb_a && reg_sel_a == 4'h0), 32'h0);
            chk("r_wrb_b", 32'(!wrb_b && reg_sel_b == 3'h0), 32'h0);
            chk("r_pulse_a", 32'($onehot0(gnt_a | done_a | err_a)), 32'h1);
            chk("r_pulse_b", 32'($onehot0(gnt_b | done_b | err_b)), 32'h1);
            chk("r_follow_a", 32'(done_a | err_a), 32'(ga2));
            chk("r_follow_b", 32'(done_b | err_b), 32'(gb2));
            ga2 = ga1; ga1 = gnt_a;
            gb2 = gb1; gb1 = gnt_b;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
